// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message sequencer: FSM states,
// HD44780 command bytes, sequence-index landmarks and the per-index byte table.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [5:0] IDX_CLEAR = 6'd2;
    localparam logic [5:0] IDX_LINE1 = 6'd4;
    localparam logic [5:0] IDX_LINE2 = 6'd21;
    localparam logic [5:0] IDX_LAST  = 6'd37;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_xfer_t;

    // Char c of a line sits at bits [127-8c -: 8]; {~c,3'b000} is 8*(15-c).
    function automatic lcd_xfer_t seq_entry(input logic [5:0]   idx,
                                            input logic [127:0] l1,
                                            input logic [127:0] l2);
        lcd_xfer_t  e;
        logic [3:0] c;
        e.rs   = 1'b0;
        e.data = 8'h00;
        c      = 4'd0;
        if (idx > IDX_LINE1 && idx < IDX_LINE2) begin
            c      = 4'(idx - 6'd5);
            e.rs   = 1'b1;
            e.data = l1[{~c, 3'b000} +: 8];
        end else if (idx > IDX_LINE2 && idx <= IDX_LAST) begin
            c      = 4'(idx - 6'd22);
            e.rs   = 1'b1;
            e.data = l2[{~c, 3'b000} +: 8];
        end else begin
            case (idx)
                6'd0:      e.data = LCD_FUNC_SET;
                6'd1:      e.data = LCD_DISP_ON;
                IDX_CLEAR: e.data = LCD_CLEAR;
                6'd3:      e.data = LCD_ENTRY;
                IDX_LINE1: e.data = LCD_LINE1;
                IDX_LINE2: e.data = LCD_LINE2;
                default:   e.data = 8'h00;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/lcd_msg_sequencer_if.sv
// Byte-write handshake between the message sequencer and the LCD write controller.
interface lcd_msg_sequencer_if;
    // ctrl_Start is a one-cycle pulse carrying ctrl_RS/ctrl_DATA, which stay stable
    // until the controller finishes; ctrl_Done is a level whose rising edge marks
    // completion and which stays high until the next accepted start.
    logic       ctrl_Start;
    logic       ctrl_RS;
    logic [7:0] ctrl_DATA;
    logic       ctrl_Done;

    modport master (output ctrl_Start, output ctrl_RS, output ctrl_DATA, input ctrl_Done);
    modport slave  (input ctrl_Start, input ctrl_RS, input ctrl_DATA, output ctrl_Done);
endinterface

// File: rtl/lcd_wait_timer.sv
// Saturating wait counter: 'start' loads a terminal count, 'done' pulses once
// when the count reaches it. Comes out of reset already running RST_LOAD.
module lcd_wait_timer #(
    parameter int            TW       = 20,
    parameter logic [TW-1:0] RST_LOAD = '0
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          start,
    input  logic [TW-1:0] load,
    output logic          done
);

    logic [TW-1:0] count;
    logic [TW-1:0] target;
    logic          running;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            count   <= '0;
            target  <= RST_LOAD;
            running <= 1'b1;
        end else if (start) begin
            count   <= '0;
            target  <= load;
            running <= 1'b1;
        end else if (running) begin
            if (count == target) begin
                running <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign done = running && (count == target);

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Drives the LCD byte-write controller: power-up init, two 16-char lines, and
// on request a refresh of both lines from a snapshot, with command gaps.
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT = 750000,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 82000
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iStart,
    input  logic [127:0]         iLine1,
    input  logic [127:0]         iLine2,
    output logic                 oReady,
    lcd_msg_sequencer_if.master  ctrl,
    output state_t               dbg_state,
    output logic [5:0]           dbg_index
);

    localparam int MAX_WAIT = (PWR_WAIT > CMD_WAIT)
                            ? ((PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT)
                            : ((CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT);
    // +1 so a power-of-two wait still fits its own terminal value.
    localparam int TW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t        state;
    logic [5:0]    index;
    logic [5:0]    nxt_index;
    logic [127:0]  line1_q;
    logic [127:0]  line2_q;
    logic [127:0]  nxt_line1;
    logic [127:0]  nxt_line2;
    lcd_xfer_t     nxt_xfer;
    logic          done_q;
    logic          done_rise;
    logic          start_q;
    logic          ready_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          tmr_start;
    logic          tmr_done;
    logic [TW-1:0] tmr_load;

    assign done_rise = ctrl.ctrl_Done & ~done_q;

    // The byte for the next transaction is computed from the text being captured
    // in the same cycle when entering from power-up or idle.
    always_comb begin
        nxt_index = index + 6'd1;
        nxt_line1 = line1_q;
        nxt_line2 = line2_q;
        if (state == S_PWRUP) begin
            nxt_index = 6'd0;
            nxt_line1 = iLine1;
            nxt_line2 = iLine2;
        end else if (state == S_IDLE) begin
            nxt_index = IDX_LINE1;
            nxt_line1 = iLine1;
            nxt_line2 = iLine2;
        end
        nxt_xfer = seq_entry(nxt_index, nxt_line1, nxt_line2);
    end

    always_comb begin
        tmr_start = (state == S_WAIT) && done_rise;
        tmr_load  = (index == IDX_CLEAR) ? TW'(CLR_WAIT) : TW'(CMD_WAIT);
    end

    lcd_wait_timer #(
        .TW       (TW),
        .RST_LOAD (TW'(PWR_WAIT))
    ) u_timer (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .start  (tmr_start),
        .load   (tmr_load),
        .done   (tmr_done)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= S_PWRUP;
            index   <= 6'd0;
            line1_q <= {16{8'h20}};
            line2_q <= {16{8'h20}};
            done_q  <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            done_q  <= ctrl.ctrl_Done;
            start_q <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (tmr_done) begin
                        line1_q <= iLine1;
                        line2_q <= iLine2;
                        index   <= nxt_index;
                        rs_q    <= nxt_xfer.rs;
                        data_q  <= nxt_xfer.data;
                        start_q <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // A Done still high from the previous transaction has no edge.
                    if (done_rise) state <= S_GAP;
                end
                S_GAP: begin
                    if (tmr_done) begin
                        if (index == IDX_LAST) begin
                            ready_q <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            index   <= nxt_index;
                            rs_q    <= nxt_xfer.rs;
                            data_q  <= nxt_xfer.data;
                            start_q <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_IDLE: begin
                    if (iStart) begin
                        line1_q <= iLine1;
                        line2_q <= iLine2;
                        index   <= nxt_index;
                        rs_q    <= nxt_xfer.rs;
                        data_q  <= nxt_xfer.data;
                        start_q <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

    assign ctrl.ctrl_Start = start_q;
    assign ctrl.ctrl_RS    = rs_q;
    assign ctrl.ctrl_DATA  = data_q;
    assign oReady          = ready_q;
    assign dbg_state       = state;
    assign dbg_index       = index;

endmodule
